ping_pong_seg_display: RTL and testbench
========================================

// Module: ping_pong_seg_display
// PURPOSE
//  Downstream display stage for the parameterized ping-pong counter.
//  - Consumes the counter's 4-bit value and direction bit.
//  - Drives a 4-digit, common-anode, time-multiplexed 7-segment display:
//    - an[3]/an[2]: decimal tens/ones of the value.
//    - an[1]/an[0]: direction text, "UP" or "dn".
//  - Inputs are snapshotted once per scan frame, so all digits in a frame show one consistent value.
// PARAMETERS
//  DIV_COUNT  100000  clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20
// PORTS
//  clk        in   1  system clock; all state updates on posedge
//  rst_n      in   1  asynchronous active-low reset
//  value      in   4  counter output, 0..15
//  direction  in   1  counter direction: 1 = counting up, 0 = counting down
//  an         out  4  digit enables, active-low; an[3] = leftmost digit
//  seg        out  7  segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (async assert, sync-free release)
//   - an = 4'b1111, seg = 7'b1111111, div_cnt = 0, ptr = 2'd0.
//   - Snapshot registers: snap_val = 0, snap_dir = 1.
//  Divider
//   - div_cnt has ceil(log2(DIV_COUNT)) bits and increments every clk.
//   - tick = (div_cnt == DIV_COUNT-1). On tick, div_cnt wraps to 0.
//   - First tick occurs on the DIV_COUNT-th posedge after reset release.
//  Digit pointer (4-state ring, advances only on tick)
//   - Sequence: 0 -> 3 -> 2 -> 1 -> 0, i.e. ptr_next = ptr - 1 mod 4.
//   - an and seg are registers, loaded on tick with the decode for ptr_next.
//   - an = ~(4'b0001 << ptr_next): exactly one digit low after the first tick. No blank gap between slots.
//   - Between ticks, an and seg hold their values.
//  Snapshot
//   - On a tick where ptr == 0 (frame start): snap_val <= value, snap_dir <= direction.
//   - The digit-3 decode loaded on that same tick uses the live value, not the old snapshot.
//   - Digits 2, 1 and 0 of that frame use the new snapshot.
//   - Input changes mid-frame never appear before the next frame.
//  Decode
//   - tens = (v >= 10), ones = v - 10*tens.
//   - Digit 3 is blanked (7'b1111111) when tens == 0; otherwise it shows "1".
//   - Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//     5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//   - direction=1: digit1 = "U" (1000001), digit0 = "P" (0001100).
//   - direction=0: digit1 = "d" (0100001), digit0 = "n" (0101011).
//  Boundaries
//   - value 9 -> 10: the blanked tens digit becomes "1" at the next frame start.
//   - value = 15: digits show "15".
//   - No illegal inputs exist; all 16 values decode.
//   - direction flipping at the same edge as a frame-start tick: the new direction is captured.
//   - rst_n low mid-frame: outputs return to reset values immediately (async), without waiting for clk.
//   - After release, the sequence restarts from ptr = 0.
//   - DIV_COUNT = 2 is legal: a tick occurs every other cycle.
// TESTING  (bench uses DIV_COUNT = 4, 2 ns clk)
//  1. Reset, then hold value=7, direction=1.
//     -> an stays 1111 for 3 cycles; on the 4th posedge an = 0111 and seg = 1111111 (blank tens).
//     -> Next slots: an = 1011 / seg = 1111000; an = 1101 / seg = 1000001; an = 1110 / seg = 0001100.
//  2. value=12, direction=0.
//     -> Over one frame seg shows 1111001, 0100100, 0100001, 0101011 on an 0111, 1011, 1101, 1110.
//  3. Change value 3 -> 14 while an = 1011 (mid-frame).
//     -> Remaining digits of that frame still show "3"/direction; the next frame shows "14".
//  4. Toggle direction on the same edge as a frame-start tick.
//     -> digit1/digit0 of that frame show the new direction text.
//  5. Assert rst_n low between clk edges while an = 1101.
//     -> an = 1111 and seg = 1111111 before the next posedge.
//     -> After release, the first digit (an = 0111) appears 4 cycles later.
//  6. Sweep value 0..15.
//     -> All 16 decodes match the table; digit 3 is blank for values 0..9.

Source files
------------

// File: rtl/ping_pong_seg_display.sv
// ping_pong_seg_display: 4-digit common-anode multiplexed 7-segment driver
// for the ping-pong counter. Left pair shows the value in decimal, right
// pair shows "UP"/"dn". Inputs are snapshotted at each frame start so a
// whole frame shows one consistent value.
module ping_pong_seg_display #(
    parameter int DIV_COUNT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] value,
    input  logic       direction,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_COUNT - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_N     = 7'b0101011;

    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    ptr;
    logic [1:0]    ptr_next;
    logic [3:0]    snap_val;
    logic          snap_dir;
    logic [3:0]    dig_val;
    logic          tens;
    logic [3:0]    ones;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] dec_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Slot decode for the digit that becomes active on the next tick.
    // The frame-start slot (digit 3) reads the live input because the
    // snapshot is being loaded on that very tick.
    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        ptr_next = ptr - 2'd1;
        dig_val  = (ptr == 2'd0) ? value : snap_val;
        tens     = (dig_val >= 4'd10);
        ones     = tens ? (dig_val - 4'd10) : dig_val;
        an_next  = ~(4'b0001 << ptr_next);
        seg_next = SEG_BLANK;
        case (ptr_next)
            2'd3: seg_next = tens ? dec_digit(4'd1) : SEG_BLANK;
            2'd2: seg_next = dec_digit(ones);
            2'd1: seg_next = snap_dir ? SEG_U : SEG_D;
            2'd0: seg_next = snap_dir ? SEG_P : SEG_N;
            default: seg_next = SEG_BLANK;
        endcase
    end

    // Slot-rate divider: wraps to 0 on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // Digit ring, registered outputs and frame-start snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 2'd0;
            an       <= 4'b1111;
            seg      <= SEG_BLANK;
            snap_val <= 4'd0;
            snap_dir <= 1'b1;
        end else if (tick) begin
            ptr <= ptr_next;
            an  <= an_next;
            seg <= seg_next;
            if (ptr == 2'd0) begin
                snap_val <= value;
                snap_dir <= direction;
            end
        end
    end

endmodule

// File: tb/tb_ping_pong_seg_display.sv
// Scoreboard bench for ping_pong_seg_display (DIV_COUNT = 4, 2 ns clock).
// Expected {an,seg} slots are queued when stimulus is set; a negedge
// monitor pops one entry whenever a new digit slot appears.
`timescale 1ns/100ps
module tb_ping_pong_seg_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] value = 4'd7;
    logic       direction = 1'b1;
    logic [3:0] an;
    logic [6:0] seg;

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;
    logic [3:0]  prev_an = 4'b1111;
    logic [10:0] sb_q[$];
    logic [6:0]  dig_tab [0:9];

    localparam logic [6:0] BLANK = 7'b1111111;

    ping_pong_seg_display #(.DIV_COUNT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .value(value), .direction(direction),
        .an(an), .seg(seg)
    );

    always #1 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Queue the four slots of one frame showing value v and direction d.
    task automatic push_frame(input int v, input bit d);
        sb_q.push_back({4'b0111, (v >= 10) ? dig_tab[1] : BLANK});
        sb_q.push_back({4'b1011, dig_tab[v % 10]});
        sb_q.push_back({4'b1101, d ? 7'b1000001 : 7'b0100001});
        sb_q.push_back({4'b1110, d ? 7'b0001100 : 7'b0101011});
    endtask

    // Return at the first negedge on which an has just become target.
    task automatic wait_slot(input logic [3:0] target);
        logic [3:0] last;
        bit hit;
        last = an;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (an == target && last != target) hit = 1'b1;
            last = an;
        end
        if (!hit) chk("wait_slot_timeout", {28'd0, an}, {28'd0, target});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic release_and_check_first(input logic [6:0] first_seg);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #0.5;
            chk("pre_tick_an", {28'd0, an}, 32'hf);
        end
        @(posedge clk); #0.5;
        chk("first_an", {28'd0, an}, 32'h7);
        chk("first_seg", {25'd0, seg}, {25'd0, first_seg});
    endtask

    // Scoreboard monitor: each new digit slot must match the queue head.
    always @(negedge clk) begin
        logic [10:0] exp;
        if (mon_en && an != prev_an && an != 4'b1111) begin
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 11'h7ff;
            chk("slot", {21'd0, an, seg}, {21'd0, exp});
        end
        prev_an <= an;
    end

    initial begin
        dig_tab[0] = 7'b1000000; dig_tab[1] = 7'b1111001;
        dig_tab[2] = 7'b0100100; dig_tab[3] = 7'b0110000;
        dig_tab[4] = 7'b0011001; dig_tab[5] = 7'b0010010;
        dig_tab[6] = 7'b0000010; dig_tab[7] = 7'b1111000;
        dig_tab[8] = 7'b0000000; dig_tab[9] = 7'b0010000;

        // 1: reset state, then value 7 / UP
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hf);
        chk("rst_seg", {25'd0, seg}, 32'h7f);
        push_frame(7, 1'b1);
        mon_en = 1'b1;
        release_and_check_first(BLANK);

        // 2: value 12 / dn
        wait_slot(4'b1110);
        value = 4'd12; direction = 1'b0;
        push_frame(12, 1'b0);

        // 3: value 3, then 14 mid-frame
        wait_slot(4'b1110);
        value = 4'd3; direction = 1'b1;
        push_frame(3, 1'b1);
        wait_slot(4'b1011);
        value = 4'd14;
        push_frame(14, 1'b1);

        // 4: direction flips right before a frame-start tick
        wait_slot(4'b1110);
        wait_slot(4'b1110);
        repeat (3) @(negedge clk);
        direction = 1'b0;
        push_frame(14, 1'b0);

        // 5: async reset mid-frame
        wait_slot(4'b1101);
        mon_en = 1'b0;
        #0.5 rst_n = 1'b0;
        #0.2;
        chk("async_rst_an", {28'd0, an}, 32'hf);
        chk("async_rst_seg", {25'd0, seg}, 32'h7f);
        sb_q.delete();
        repeat (3) @(negedge clk);
        value = 4'd5; direction = 1'b1;
        push_frame(5, 1'b1);
        mon_en = 1'b1;
        release_and_check_first(BLANK);

        // 6: sweep all values, alternating direction
        for (int v = 0; v < 16; v++) begin
            wait_slot(4'b1110);
            value = 4'(v); direction = v[0];
            push_frame(v, v[0]);
        end
        wait_drain();
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
